// File: rtl/rv32_ctrl_pkg.sv
// Shared encodings for the RV32I multi-cycle control path: opcodes, FSM states,
// instruction classes, ALU ops and datapath select codes.
package rv32_ctrl_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_e;

  typedef enum logic [3:0] {
    CLS_ILL, CLS_LUI, CLS_AUIPC, CLS_JAL, CLS_JALR, CLS_BRANCH,
    CLS_LOAD, CLS_STORE, CLS_OPIMM, CLS_OP
  } class_e;

  localparam logic [3:0] ALU_ADD    = 4'd0;
  localparam logic [3:0] ALU_SUB    = 4'd1;
  localparam logic [3:0] ALU_SLL    = 4'd2;
  localparam logic [3:0] ALU_SLT    = 4'd3;
  localparam logic [3:0] ALU_SLTU   = 4'd4;
  localparam logic [3:0] ALU_XOR    = 4'd5;
  localparam logic [3:0] ALU_SRL    = 4'd6;
  localparam logic [3:0] ALU_SRA    = 4'd7;
  localparam logic [3:0] ALU_OR     = 4'd8;
  localparam logic [3:0] ALU_AND    = 4'd9;
  localparam logic [3:0] ALU_PASS_B = 4'd10;

  localparam logic [2:0] IMM_I = 3'd0;
  localparam logic [2:0] IMM_S = 3'd1;
  localparam logic [2:0] IMM_B = 3'd2;
  localparam logic [2:0] IMM_U = 3'd3;
  localparam logic [2:0] IMM_J = 3'd4;

  localparam logic [1:0] PC_SEL_PC4  = 2'd0;
  localparam logic [1:0] PC_SEL_IMM  = 2'd1;
  localparam logic [1:0] PC_SEL_JALR = 2'd2;

  localparam logic [1:0] WB_SEL_ALU  = 2'd0;
  localparam logic [1:0] WB_SEL_LOAD = 2'd1;
  localparam logic [1:0] WB_SEL_PC4  = 2'd2;
  localparam logic [1:0] WB_SEL_IMM  = 2'd3;

  localparam logic [1:0] TRAP_NONE    = 2'd0;
  localparam logic [1:0] TRAP_ILLEGAL = 2'd1;
  localparam logic [1:0] TRAP_TIMEOUT = 2'd2;

  // alt selects SUB at f3=000 and SRA at f3=101 (funct7 bit 5)
  function automatic logic [3:0] alu_from_f3(input logic [2:0] f3, input logic alt);
    case (f3)
      3'b000:  return alt ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

endpackage

// File: rtl/rv32_op_decode.sv
// Combinational RV32I field decode: legality, instruction class and datapath selects.
// Zero latency; no flow control.
module rv32_op_decode
  import rv32_ctrl_pkg::*;
(
  input  logic [6:0] cmd_op_i,
  input  logic [2:0] cmd_f3_i,
  input  logic [6:0] cmd_f7_i,
  output logic       legal_o,
  output class_e     cls_o,
  output logic [3:0] alu_op_o,
  output logic       alu_a_pc_o,
  output logic       alu_b_imm_o,
  output logic [2:0] imm_type_o,
  output logic [1:0] wb_sel_o
);

  logic f7_zero, f7_alt;
  assign f7_zero = (cmd_f7_i == 7'b0000000);
  assign f7_alt  = (cmd_f7_i == 7'b0100000);

  always_comb begin
    legal_o     = 1'b0;
    cls_o       = CLS_ILL;
    alu_op_o    = ALU_ADD;
    alu_a_pc_o  = 1'b0;
    alu_b_imm_o = 1'b0;
    imm_type_o  = IMM_I;
    wb_sel_o    = WB_SEL_ALU;
    case (cmd_op_i)
      OPC_LUI: begin
        legal_o = 1'b1; cls_o = CLS_LUI; alu_op_o = ALU_PASS_B;
        alu_b_imm_o = 1'b1; imm_type_o = IMM_U; wb_sel_o = WB_SEL_IMM;
      end
      OPC_AUIPC: begin
        legal_o = 1'b1; cls_o = CLS_AUIPC; alu_a_pc_o = 1'b1;
        alu_b_imm_o = 1'b1; imm_type_o = IMM_U;
      end
      OPC_JAL: begin
        legal_o = 1'b1; cls_o = CLS_JAL; imm_type_o = IMM_J; wb_sel_o = WB_SEL_PC4;
      end
      OPC_JALR: begin
        legal_o = (cmd_f3_i == 3'b000); cls_o = CLS_JALR;
        alu_b_imm_o = 1'b1; wb_sel_o = WB_SEL_PC4;
      end
      OPC_BRANCH: begin
        legal_o = (cmd_f3_i != 3'b010) && (cmd_f3_i != 3'b011);
        cls_o = CLS_BRANCH; alu_op_o = ALU_SUB; imm_type_o = IMM_B;
      end
      OPC_LOAD: begin
        legal_o = cmd_f3_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        cls_o = CLS_LOAD; alu_b_imm_o = 1'b1; wb_sel_o = WB_SEL_LOAD;
      end
      OPC_STORE: begin
        legal_o = cmd_f3_i inside {3'b000, 3'b001, 3'b010};
        cls_o = CLS_STORE; alu_b_imm_o = 1'b1; imm_type_o = IMM_S;
      end
      OPC_OPIMM: begin
        cls_o = CLS_OPIMM; alu_b_imm_o = 1'b1;
        alu_op_o = alu_from_f3(cmd_f3_i, (cmd_f3_i == 3'b101) && cmd_f7_i[5]);
        if (cmd_f3_i == 3'b001)      legal_o = f7_zero;
        else if (cmd_f3_i == 3'b101) legal_o = f7_zero || f7_alt;
        else                         legal_o = 1'b1;
      end
      OPC_OP: begin
        cls_o    = CLS_OP;
        alu_op_o = alu_from_f3(cmd_f3_i, cmd_f7_i[5]);
        legal_o  = f7_zero || (f7_alt && (cmd_f3_i == 3'b000 || cmd_f3_i == 3'b101));
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// RV32I multi-cycle control FSM: FETCH/DECODE/EXEC/MEM/WB with sticky trap.
// 3-5 cycles per instruction plus one per memory wait cycle; mem_req held until mem_ready.
module multicycle_ctrl
  import rv32_ctrl_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] cmdOp,
  input  logic [2:0] cmdF3,
  input  logic [6:0] cmdF7,
  input  logic       br_taken,
  input  logic       mem_ready,
  output logic       mem_req,
  output logic       mem_we,
  output logic       ir_we,
  output logic       pc_we,
  output logic [1:0] pc_sel,
  output logic       reg_we,
  output logic [1:0] wb_sel,
  output logic [3:0] alu_op,
  output logic       alu_a_pc,
  output logic       alu_b_imm,
  output logic [2:0] imm_type,
  output logic       trap,
  output logic [1:0] trap_cause
);

  localparam logic [8:0] TO_LIM = 9'(MEM_TIMEOUT);

  state_e     state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic [1:0] cause_q, cause_d;

  logic       dec_legal, dec_a_pc, dec_b_imm;
  class_e     dec_cls;
  logic [3:0] dec_alu_op;
  logic [2:0] dec_imm;
  logic [1:0] dec_wb;
  logic       timeout_hit;

  rv32_op_decode u_dec (
    .cmd_op_i    (cmdOp),
    .cmd_f3_i    (cmdF3),
    .cmd_f7_i    (cmdF7),
    .legal_o     (dec_legal),
    .cls_o       (dec_cls),
    .alu_op_o    (dec_alu_op),
    .alu_a_pc_o  (dec_a_pc),
    .alu_b_imm_o (dec_b_imm),
    .imm_type_o  (dec_imm),
    .wb_sel_o    (dec_wb)
  );

  // this wait cycle would be the MEM_TIMEOUT-th one without mem_ready
  assign timeout_hit = ({1'b0, cnt_q} + 9'd1) >= TO_LIM;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_FETCH;
      cnt_q   <= '0;
      cause_q <= TRAP_NONE;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cause_q <= cause_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cause_d   = cause_q;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_sel    = PC_SEL_PC4;
    reg_we    = 1'b0;
    wb_sel    = WB_SEL_ALU;
    alu_op    = ALU_ADD;
    alu_a_pc  = 1'b0;
    alu_b_imm = 1'b0;
    imm_type  = IMM_I;

    // keep operand selects stable from EXEC through write-back
    if (state_q inside {S_EXEC, S_MEM, S_WB}) begin
      alu_op    = dec_alu_op;
      alu_a_pc  = dec_a_pc;
      alu_b_imm = dec_b_imm;
      imm_type  = dec_imm;
    end

    case (state_q)
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_we   = 1'b1;
          state_d = S_DECODE;
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_DECODE: begin
        if (dec_legal) begin
          state_d = S_EXEC;
        end else begin
          state_d = S_TRAP;
          cause_d = TRAP_ILLEGAL;
        end
      end
      S_EXEC: begin
        if (dec_cls == CLS_BRANCH) begin
          pc_we   = 1'b1;
          pc_sel  = br_taken ? PC_SEL_IMM : PC_SEL_PC4;
          state_d = S_FETCH;
        end else if (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) begin
          state_d = S_MEM;
        end else begin
          state_d = S_WB;
        end
      end
      S_MEM: begin
        mem_req = 1'b1;
        mem_we  = (dec_cls == CLS_STORE);
        if (mem_ready) begin
          if (dec_cls == CLS_STORE) begin
            pc_we   = 1'b1;
            state_d = S_FETCH;
          end else begin
            state_d = S_WB;
          end
        end else if (timeout_hit) begin
          state_d = S_TRAP;
          cause_d = TRAP_TIMEOUT;
        end
      end
      S_WB: begin
        reg_we  = 1'b1;
        wb_sel  = dec_wb;
        pc_we   = 1'b1;
        if (dec_cls == CLS_JAL)       pc_sel = PC_SEL_IMM;
        else if (dec_cls == CLS_JALR) pc_sel = PC_SEL_JALR;
        state_d = S_FETCH;
      end
      default: ;
    endcase

    cnt_d = cnt_q;
    if (state_d != state_q || mem_ready) cnt_d = '0;
    else if (mem_req)                    cnt_d = cnt_q + 8'd1;
  end

  assign trap       = (state_q == S_TRAP);
  assign trap_cause = cause_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: per-cycle expected outputs are queued as stimulus
// is driven and compared (under a field mask) by a negedge monitor.
module tb_multicycle_ctrl;
  import rv32_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0;
  logic        br_taken = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, mem_we, ir_we, pc_we, reg_we, alu_a_pc, alu_b_imm, trap;
  logic [1:0]  pc_sel, wb_sel, trap_cause;
  logic [3:0]  alu_op;
  logic [2:0]  imm_type;

  always #5 clk = ~clk;

  multicycle_ctrl #(.MEM_TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .cmdOp(ir[6:0]), .cmdF3(ir[14:12]), .cmdF7(ir[31:25]),
    .br_taken(br_taken), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_we(mem_we), .ir_we(ir_we), .pc_we(pc_we), .pc_sel(pc_sel),
    .reg_we(reg_we), .wb_sel(wb_sel), .alu_op(alu_op), .alu_a_pc(alu_a_pc),
    .alu_b_imm(alu_b_imm), .imm_type(imm_type), .trap(trap), .trap_cause(trap_cause)
  );

  // {mem_req,mem_we,ir_we,pc_we,pc_sel[16:15],reg_we,wb_sel[13:12],alu_op[11:8],a_pc,b_imm,imm[5:3],trap,cause}
  wire [20:0] obs = {mem_req, mem_we, ir_we, pc_we, pc_sel, reg_we, wb_sel,
                     alu_op, alu_a_pc, alu_b_imm, imm_type, trap, trap_cause};

  localparam logic [20:0] M_PCS  = 21'h18000;
  localparam logic [20:0] M_WBS  = 21'h03000;
  localparam logic [20:0] M_ALU  = 21'h00FF8;
  localparam logic [20:0] M_BASE = 21'h1FFFFF & ~(M_PCS | M_WBS | M_ALU);
  localparam logic [20:0] A_IMM  = 21'h00038;
  localparam logic [20:0] A_NOIMM = 21'h00FC0;
  localparam logic [20:0] A_LUI  = 21'h00F78;

  localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4;

  typedef struct {
    logic [20:0] val;
    logic [20:0] msk;
    string       tag;
  } exp_t;

  typedef struct {
    logic [31:0] ir;
    int          kind;
    logic [3:0]  aop;
    logic        apc;
    logic        bimm;
    logic [2:0]  imt;
    logic [20:0] amsk;
    logic [1:0]  wbs;
    logic [1:0]  pcs;
  } ins_t;

  exp_t sb[$];
  exp_t mon_e;
  int   total = 0;
  int   bad = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  function automatic logic [20:0] pk(input logic mreq, input logic mwe, input logic irwe,
      input logic pcwe, input logic [1:0] pcs, input logic regwe, input logic [1:0] wbs,
      input logic [3:0] aop, input logic apc, input logic bimm, input logic [2:0] imt,
      input logic trp, input logic [1:0] cause);
    return {mreq, mwe, irwe, pcwe, pcs, regwe, wbs, aop, apc, bimm, imt, trp, cause};
  endfunction

  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      chk(mon_e.tag, 32'(obs & mon_e.msk), 32'(mon_e.val & mon_e.msk));
    end
  end

  task automatic cyc(input logic rdy, input logic br, input logic [20:0] v,
                     input logic [20:0] m, input string tag);
    exp_t e;
    mem_ready = rdy;
    br_taken  = br;
    e.val = v; e.msk = m; e.tag = $sformatf("%h/%s", ir, tag);
    sb.push_back(e);
    @(posedge clk); #1;
  endtask

  task automatic run(input ins_t t, input int fw, input int mw, input logic br);
    logic last, st;
    ir = t.ir;
    for (int w = 0; w <= fw; w++)
      cyc(w == fw, 1'b0, pk(1,0,(w == fw),0,0,0,0,0,0,0,0,0,0), M_BASE, "fetch");
    cyc(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0), M_BASE, "decode");
    if (t.kind == K_ILL) begin
      repeat (3) cyc(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,0,1,TRAP_ILLEGAL), M_BASE, "trap_ill");
      return;
    end
    cyc(1'b0, br, pk(0,0,0,(t.kind == K_BR),(br ? PC_SEL_IMM : PC_SEL_PC4),0,0,
                     t.aop,t.apc,t.bimm,t.imt,0,0),
        M_BASE | t.amsk | ((t.kind == K_BR) ? M_PCS : 21'h0), "exec");
    if (t.kind == K_BR) return;
    if (t.kind == K_LD || t.kind == K_ST) begin
      st = (t.kind == K_ST);
      for (int w = 0; w <= mw; w++) begin
        last = (w == mw);
        cyc(last, 1'b0, pk(1,st,0,(last && st),PC_SEL_PC4,0,0,0,0,0,0,0,0),
            M_BASE | ((last && st) ? M_PCS : 21'h0), "mem");
      end
      if (st) return;
    end
    cyc(1'b0, 1'b0, pk(0,0,0,1,t.pcs,1,t.wbs,0,0,0,0,0,0), M_BASE | M_PCS | M_WBS, "wb");
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1; mem_ready = 1'b0; br_taken = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    chk(tag, {29'd0, trap, trap_cause}, 32'd0);
  endtask

  ins_t i_add, i_lw, i_sw, i_beq, i_lui, i_jal, i_jalr, i_auipc, i_srai, i_sub;
  ins_t i_ill_ff, i_ill_op, i_ill_br;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    i_add   = '{32'h002081B3, K_ALU, ALU_ADD,    1'b0, 1'b0, IMM_I, A_NOIMM, WB_SEL_ALU,  PC_SEL_PC4};
    i_lw    = '{32'h0040A283, K_LD,  ALU_ADD,    1'b0, 1'b1, IMM_I, M_ALU,   WB_SEL_LOAD, PC_SEL_PC4};
    i_sw    = '{32'h0020A423, K_ST,  ALU_ADD,    1'b0, 1'b1, IMM_S, M_ALU,   WB_SEL_ALU,  PC_SEL_PC4};
    i_beq   = '{32'h00208463, K_BR,  ALU_ADD,    1'b0, 1'b0, IMM_B, A_IMM,   WB_SEL_ALU,  PC_SEL_PC4};
    i_lui   = '{32'h123450B7, K_ALU, ALU_PASS_B, 1'b0, 1'b1, IMM_U, A_LUI,   WB_SEL_IMM,  PC_SEL_PC4};
    i_jal   = '{32'h010000EF, K_ALU, ALU_ADD,    1'b0, 1'b0, IMM_J, A_IMM,   WB_SEL_PC4,  PC_SEL_IMM};
    i_jalr  = '{32'h000100E7, K_ALU, ALU_ADD,    1'b0, 1'b1, IMM_I, M_ALU,   WB_SEL_PC4,  PC_SEL_JALR};
    i_auipc = '{32'h00001097, K_ALU, ALU_ADD,    1'b1, 1'b1, IMM_U, M_ALU,   WB_SEL_ALU,  PC_SEL_PC4};
    i_srai  = '{32'h40315093, K_ALU, ALU_SRA,    1'b0, 1'b1, IMM_I, M_ALU,   WB_SEL_ALU,  PC_SEL_PC4};
    i_sub   = '{32'h403100B3, K_ALU, ALU_SUB,    1'b0, 1'b0, IMM_I, A_NOIMM, WB_SEL_ALU,  PC_SEL_PC4};
    i_ill_ff = '{32'hFFFFFFFF, K_ILL, ALU_ADD, 1'b0, 1'b0, IMM_I, 21'h0, WB_SEL_ALU, PC_SEL_PC4};
    i_ill_op = '{32'h403110B3, K_ILL, ALU_ADD, 1'b0, 1'b0, IMM_I, 21'h0, WB_SEL_ALU, PC_SEL_PC4};
    i_ill_br = '{32'h0020A063, K_ILL, ALU_ADD, 1'b0, 1'b0, IMM_I, 21'h0, WB_SEL_ALU, PC_SEL_PC4};

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk("rst_out", {25'd0, trap, trap_cause, mem_req, mem_we, pc_we, reg_we}, 32'h08);

    run(i_add,   0, 0, 1'b0);
    run(i_lw,    0, 2, 1'b0);
    run(i_sw,    0, 0, 1'b0);
    run(i_beq,   0, 0, 1'b1);
    run(i_beq,   0, 0, 1'b0);
    run(i_lui,   1, 0, 1'b0);
    run(i_jal,   0, 0, 1'b0);
    run(i_jalr,  0, 0, 1'b0);
    run(i_auipc, 0, 0, 1'b0);
    run(i_srai,  0, 0, 1'b0);
    run(i_sw,    0, 3, 1'b0);
    run(i_sub,  14, 0, 1'b0);

    run(i_ill_ff, 0, 0, 1'b0);
    do_reset("rst_after_ill_ff");
    run(i_ill_op, 0, 0, 1'b0);
    do_reset("rst_after_ill_op");
    run(i_ill_br, 0, 0, 1'b0);
    do_reset("rst_after_ill_br");

    ir = i_add.ir;
    for (int w = 0; w < 15; w++)
      cyc(1'b0, 1'b0, pk(1,0,0,0,0,0,0,0,0,0,0,0,0), M_BASE, "to_wait");
    repeat (2) cyc(1'b1, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,0,1,TRAP_TIMEOUT), M_BASE, "to_trap");
    do_reset("rst_after_timeout");

    ir = i_sw.ir;
    cyc(1'b1, 1'b0, pk(1,0,1,0,0,0,0,0,0,0,0,0,0), M_BASE, "fetch");
    cyc(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0), M_BASE, "decode");
    cyc(1'b0, 1'b0, pk(0,0,0,0,0,0,0,0,0,0,0,0,0), M_BASE, "exec");
    cyc(1'b0, 1'b0, pk(1,1,0,0,0,0,0,0,0,0,0,0,0), M_BASE, "mem_wait");
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    run(i_add, 0, 0, 1'b0);
    run(i_lw,  0, 0, 1'b0);

    @(negedge clk);
    chk("sb_drain", 32'(sb.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
